load_store_unit: RTL and testbench

Initiator side of the datapath's data-memory interface. Accepts one load/store per transaction from the execute stage and drives a req/ack doubleword memory port. Stores are presented as byte-lane masks; loaded data is lane-extracted, zero-extended and written back to the register file.

---
 rtl/upower_pkg.sv | 47 ++++
 rtl/lsu_lane_align.sv | 68 ++++++
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upower_pkg.sv
// Shared definitions for the load/store unit: primary opcode values, the
// access-size and FSM-state enums, and small opcode decode helpers used by
// both the top level and the lane-alignment datapath.
package upower_pkg;

  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LD  = 6'd58;
  localparam logic [5:0] OP_STB = 6'd38;
  localparam logic [5:0] OP_STH = 6'd44;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_STD = 6'd62;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_e;

  // True for any of the eight supported load/store opcodes.
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_LBZ, OP_LHZ, OP_LWZ, OP_LD,
      OP_STB, OP_STH, OP_STW, OP_STD: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  endfunction

  // True for the four load opcodes; only meaningful for legal opcodes.
  function automatic logic op_is_load(input logic [5:0] op);
    case (op)
      OP_LBZ, OP_LHZ, OP_LWZ, OP_LD: op_is_load = 1'b1;
      default:                       op_is_load = 1'b0;
    endcase
  endfunction

  // Access size of an opcode; illegal opcodes fall through to doubleword,
  // which is harmless because they never reach the memory port.
  function automatic size_e op_size(input logic [5:0] op);
    case (op)
      OP_LBZ, OP_STB: op_size = SZ_B;
      OP_LHZ, OP_STH: op_size = SZ_H;
      OP_LWZ, OP_STW: op_size = SZ_W;
      default:        op_size = SZ_D;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   size_i       access size (byte/half/word/double)
//   lane_i       byte lane within the doubleword, ea[2:0]
//   store_data_i source register value for stores
//   rdata_i      doubleword returned by memory
//   be_o         byte enables, bit i = byte lane i
//   wdata_o      store data shifted into its lanes
//   rdata_o      load data shifted down and zero-extended to 64 bits
//   misalign_o   access does not sit on its natural alignment
module lsu_lane_align
  import upower_pkg::*;
(
  input  size_e       size_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] store_data_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  be_base;
  logic [63:0] size_mask;
  logic [5:0]  bit_shift;

  // Build the size-dependent enable pattern and data mask, then move them to
  // the addressed lane. Masking the store data first keeps unused lanes of
  // mem_wdata at zero instead of carrying stray high register bits.
  always_comb begin
    be_base    = 8'h01;
    size_mask  = 64'h0000_0000_0000_00FF;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: begin
        be_base    = 8'h01;
        size_mask  = 64'h0000_0000_0000_00FF;
        misalign_o = 1'b0;
      end
      SZ_H: begin
        be_base    = 8'h03;
        size_mask  = 64'h0000_0000_0000_FFFF;
        misalign_o = lane_i[0];
      end
      SZ_W: begin
        be_base    = 8'h0F;
        size_mask  = 64'h0000_0000_FFFF_FFFF;
        misalign_o = |lane_i[1:0];
      end
      SZ_D: begin
        be_base    = 8'hFF;
        size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
        misalign_o = |lane_i;
      end
      default: begin
        be_base    = 8'h01;
        size_mask  = 64'h0000_0000_0000_00FF;
        misalign_o = 1'b0;
      end
    endcase
    bit_shift = {lane_i, 3'b000};
    be_o      = be_base << lane_i;
    wdata_o   = (store_data_i & size_mask) << bit_shift;
    rdata_o   = (rdata_i >> bit_shift) & size_mask;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface.
// Accepts one operation at a time from execute, issues a single req/ack
// doubleword access, and writes zero-extended load data back.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   op_valid/op_ready              execute-stage handshake
//   opcode, ea, store_data, rd     operation fields
//   mem_req/we/addr/wdata/be       memory request, held until mem_ack
//   mem_ack, mem_rdata             memory completion and read data
//   wb_en, wb_rd, wb_data          one-cycle register write-back
//   err_misalign/illegal/timeout   one-cycle error pulses
module load_store_unit
  import upower_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  opcode,
  input  logic [63:0] ea,
  input  logic [63:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        err_misalign,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  size_e       size_q, size_sel;
  logic [2:0]  lane_q, lane_sel;
  logic        load_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [63:0] addr_q, wdata_q, wb_data_q;
  logic [7:0]  be_q;
  logic        err_mis_q, err_mis_d;
  logic        err_ill_q, err_ill_d;
  logic        err_to_q, err_to_d;
  logic        accept;
  logic [7:0]  be_calc;
  logic [63:0] wdata_calc, rdata_calc;
  logic        misalign_calc;

  assign op_ready = (state_q == IDLE) && !rst;
  assign accept   = op_valid && op_ready;

  // While idle the aligner looks at the incoming operation (for the accept
  // checks and request setup); afterwards it follows the latched access so
  // load data can be extracted when the ack arrives.
  assign size_sel = (state_q == IDLE) ? op_size(opcode) : size_q;
  assign lane_sel = (state_q == IDLE) ? ea[2:0] : lane_q;

  lsu_lane_align u_align (
    .size_i       (size_sel),
    .lane_i       (lane_sel),
    .store_data_i (store_data),
    .rdata_i      (mem_rdata),
    .be_o         (be_calc),
    .wdata_o      (wdata_calc),
    .rdata_o      (rdata_calc),
    .misalign_o   (misalign_calc)
  );

  // Next-state logic. The timeout counter holds the number of completed
  // unacked request cycles, so the request is abandoned at the end of the
  // TIMEOUT-th cycle; an ack in that same cycle still wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_ill_d = 1'b0;
    err_mis_d = 1'b0;
    err_to_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!op_legal(opcode)) begin
            err_ill_d = 1'b1;
          end else if (misalign_calc) begin
            err_mis_d = 1'b1;
          end else begin
            state_d = ISSUE;
            cnt_d   = 8'd0;
          end
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          state_d = load_q ? WB : IDLE;
        end else if (({1'b0, cnt_q} + 9'd1) == TimeoutLim) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Request fields are captured only when a
  // legal, aligned operation is accepted, so they stay stable while mem_req
  // is held. Reset abandons any transaction without a pulse or write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      size_q    <= SZ_B;
      lane_q    <= 3'd0;
      load_q    <= 1'b0;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      be_q      <= 8'd0;
      wb_data_q <= 64'd0;
      err_mis_q <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_mis_q <= err_mis_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
      if (state_q == IDLE && state_d == ISSUE) begin
        size_q  <= op_size(opcode);
        lane_q  <= ea[2:0];
        load_q  <= op_is_load(opcode);
        rd_q    <= rd;
        we_q    <= !op_is_load(opcode);
        addr_q  <= {ea[63:3], 3'b000};
        wdata_q <= wdata_calc;
        be_q    <= be_calc;
      end
      if (state_q == ISSUE && mem_ack && load_q) begin
        wb_data_q <= rdata_calc;
      end
    end
  end

  assign mem_req      = (state_q == ISSUE);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;
  assign wb_en        = (state_q == WB);
  assign wb_rd        = rd_q;
  assign wb_data      = wb_data_q;
  assign err_misalign = err_mis_q;
  assign err_illegal  = err_ill_q;
  assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of directed operations
// with hand-computed results, a few reset sequences, and random operations
// checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [5:0]  opcode;
  logic [63:0] ea;
  logic [63:0] store_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        err_misalign;
  logic        err_illegal;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  // Operation to apply; delay = wait cycles before ack (-1 = never acked).
  typedef struct {
    logic [5:0]  opcode;
    logic [63:0] ea;
    logic [63:0] sd;
    logic [4:0]  rd;
    int          delay;
    logic [63:0] rdata;
    bit          spurious;
  } stim_t;

  // Observable result of one operation, cycles counted from accept = 0.
  // err: 0 none, 1 illegal, 2 misalign, 3 timeout, 9 anything else.
  typedef struct {
    int          req;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        we;
    int          wb;
    logic [4:0]  wbRd;
    logic [63:0] wbData;
    int          err;
    int          ready;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t e;
  } vec_t;

  vec_t vecs[$];

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .opcode       (opcode),
    .ea           (ea),
    .store_data   (store_data),
    .rd           (rd),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .err_misalign (err_misalign),
    .err_illegal  (err_illegal),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Access width in bytes, 0 for an unsupported opcode.
  function automatic int opBytes(input logic [5:0] op);
    case (op)
      6'd34, 6'd38: return 1;
      6'd40, 6'd44: return 2;
      6'd32, 6'd36: return 4;
      6'd58, 6'd62: return 8;
      default:      return 0;
    endcase
  endfunction

  function automatic bit opLoad(input logic [5:0] op);
    return (op == 6'd34) || (op == 6'd40) || (op == 6'd32) || (op == 6'd58);
  endfunction

  // Transaction-level reference: what the memory port and write-back should
  // look like for one operation, derived from byte arithmetic and the
  // accept/ack/timeout timeline.
  function automatic resp_t model(input stim_t s);
    resp_t r;
    int n, lane, k;
    logic [63:0] mask;
    r = '{req: 0, addr: 64'd0, be: 8'd0, wdata: 64'd0, we: 1'b0, wb: 0,
          wbRd: 5'd0, wbData: 64'd0, err: 0, ready: 1};
    n = opBytes(s.opcode);
    if (n == 0) begin
      r.err = 1;
      return r;
    end
    if ((s.ea % 64'(n)) != 0) begin
      r.err = 2;
      return r;
    end
    lane    = int'(s.ea % 64'd8);
    mask    = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
    r.addr  = s.ea - 64'(lane);
    r.be    = 8'(((1 << n) - 1) << lane);
    r.wdata = (s.sd & mask) << (8 * lane);
    r.we    = !opLoad(s.opcode);
    if (s.delay >= 0 && s.delay < TO) begin
      r.req = s.delay + 1;
      k     = 1 + s.delay;
      if (opLoad(s.opcode)) begin
        r.wb     = 1;
        r.wbRd   = s.rd;
        r.wbData = (s.rdata >> (8 * lane)) & mask;
        r.ready  = k + 2;
      end else begin
        r.ready = k + 1;
      end
    end else begin
      r.req   = TO;
      r.err   = 3;
      r.ready = TO + 1;
    end
    return r;
  endfunction

  // Present one operation at cycle 0 and act as the memory until op_ready
  // returns, recording everything the DUT does. Entered #1 after an edge
  // with the unit expected idle.
  task automatic applyStimulus(input stim_t s, input string tag, output resp_t o);
    int errPulses;
    bit unstable;
    o = '{req: 0, addr: 64'd0, be: 8'd0, wdata: 64'd0, we: 1'b0, wb: 0,
          wbRd: 5'd0, wbData: 64'd0, err: 0, ready: -1};
    errPulses = 0;
    unstable  = 1'b0;
    chk({tag, " ready_at_accept"}, 64'(op_ready), 64'd1);
    op_valid   = 1'b1;
    opcode     = s.opcode;
    ea         = s.ea;
    store_data = s.sd;
    rd         = s.rd;
    mem_rdata  = s.rdata;
    nextCycle();
    op_valid   = 1'b0;
    opcode     = 6'd0;
    ea         = 64'd0;
    store_data = 64'd0;
    for (int c = 1; c < 20; c++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (o.req == 0) begin
          o.addr  = mem_addr;
          o.be    = mem_be;
          o.wdata = mem_wdata;
          o.we    = mem_we;
        end else if (o.addr !== mem_addr || o.be !== mem_be ||
                     o.wdata !== mem_wdata || o.we !== mem_we) begin
          unstable = 1'b1;
        end
        o.req++;
      end
      if (wb_en) begin
        o.wb++;
        o.wbRd   = wb_rd;
        o.wbData = wb_data;
      end
      if (err_illegal)  begin errPulses++; o.err = 1; end
      if (err_misalign) begin errPulses++; o.err = 2; end
      if (err_timeout)  begin errPulses++; o.err = 3; end
      mem_ack = ((s.delay >= 0) && (c == 1 + s.delay)) || (s.spurious && !mem_req);
      if (op_ready) begin
        o.ready = c;
        break;
      end
      nextCycle();
    end
    mem_ack = 1'b0;
    if (errPulses > 1) o.err = 9;
    chk({tag, " req_stable"}, 64'(unstable), 64'd0);
  endtask

  task automatic checkOutput(input string tag, input resp_t e, input resp_t o);
    chk({tag, " ready_cycle"}, 64'(o.ready), 64'(e.ready));
    chk({tag, " req_cycles"}, 64'(o.req), 64'(e.req));
    chk({tag, " err"}, 64'(o.err), 64'(e.err));
    chk({tag, " wb_count"}, 64'(o.wb), 64'(e.wb));
    if (e.req > 0) begin
      chk({tag, " mem_addr"}, o.addr, e.addr);
      chk({tag, " mem_be"}, 64'(o.be), 64'(e.be));
      chk({tag, " mem_we"}, 64'(o.we), 64'(e.we));
      if (e.we) chk({tag, " mem_wdata"}, o.wdata, e.wdata);
    end
    if (e.wb > 0) begin
      chk({tag, " wb_rd"}, 64'(o.wbRd), 64'(e.wbRd));
      chk({tag, " wb_data"}, o.wbData, e.wbData);
    end
  endtask

  task automatic addVec(input logic [5:0] op, input logic [63:0] a, input logic [63:0] sd,
                        input logic [4:0] r, input int d, input logic [63:0] rdat, input bit sp,
                        input int eReq, input logic [63:0] eAddr, input logic [7:0] eBe,
                        input logic [63:0] eWdata, input int eWb, input logic [63:0] eWbData,
                        input int eErr, input int eReady);
    vec_t v;
    v.s = '{opcode: op, ea: a, sd: sd, rd: r, delay: d, rdata: rdat, spurious: sp};
    v.e = '{req: eReq, addr: eAddr, be: eBe, wdata: eWdata, we: !opLoad(op), wb: eWb,
            wbRd: r, wbData: eWbData, err: eErr, ready: eReady};
    vecs.push_back(v);
  endtask

  initial begin
    resp_t o;
    stim_t s;
    rst        = 1'b1;
    op_valid   = 1'b0;
    opcode     = 6'd0;
    ea         = 64'd0;
    store_data = 64'd0;
    rd         = 5'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 64'd0;

    // Reset values while rst is held.
    nextCycle();
    nextCycle();
    chk("reset op_ready", 64'(op_ready), 64'd0);
    chk("reset mem_req", 64'(mem_req), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset mem_addr", mem_addr, 64'd0);
    chk("reset mem_wdata", mem_wdata, 64'd0);
    chk("reset mem_be", 64'(mem_be), 64'd0);
    chk("reset wb", {wb_en, wb_rd, wb_data}, 64'd0);
    chk("reset errs", 64'({err_misalign, err_illegal, err_timeout}), 64'd0);
    rst = 1'b0;
    nextCycle();
    chk("post-reset op_ready", 64'(op_ready), 64'd1);

    // op, ea, sd, rd, delay, rdata, spurious | req, addr, be, wdata, wb, wbData, err, ready
    addVec(6'd38, 64'h13, 64'hAB, 5'd0, 0, 64'h0, 1'b0,
           1, 64'h10, 8'h08, 64'h0000_0000_AB00_0000, 0, 64'h0, 0, 2);
    addVec(6'd40, 64'h26, 64'h0, 5'd5, 3, 64'h1234_5678_9ABC_DEF0, 1'b0,
           4, 64'h20, 8'hC0, 64'h0, 1, 64'h1234, 0, 6);
    addVec(6'd58, 64'h40, 64'h0, 5'd7, 0, 64'hFFFF_FFFF_0000_0001, 1'b1,
           1, 64'h40, 8'hFF, 64'h0, 1, 64'hFFFF_FFFF_0000_0001, 0, 3);
    addVec(6'd32, 64'h44, 64'h0, 5'd8, 1, 64'hFFFF_FFFF_0000_0001, 1'b0,
           2, 64'h40, 8'hF0, 64'h0, 1, 64'hFFFF_FFFF, 0, 4);
    addVec(6'd36, 64'h22, 64'h1111, 5'd0, 0, 64'h0, 1'b1,
           0, 64'h0, 8'h00, 64'h0, 0, 64'h0, 2, 1);
    addVec(6'd7, 64'h0, 64'h0, 5'd1, 0, 64'h0, 1'b1,
           0, 64'h0, 8'h00, 64'h0, 0, 64'h0, 1, 1);
    addVec(6'd34, 64'h5, 64'h0, 5'd2, -1, 64'h0, 1'b0,
           4, 64'h0, 8'h20, 64'h0, 0, 64'h0, 3, 5);
    addVec(6'd62, 64'h18, 64'h0123_4567_89AB_CDEF, 5'd0, 2, 64'h0, 1'b0,
           3, 64'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 0, 4);
    addVec(6'd44, 64'hA, 64'hFFFF_BEEF, 5'd0, 4, 64'h0, 1'b0,
           4, 64'h8, 8'h0C, 64'h0000_0000_BEEF_0000, 0, 64'h0, 3, 5);
    addVec(6'd40, 64'h27, 64'h0, 5'd3, 0, 64'h0, 1'b0,
           0, 64'h0, 8'h00, 64'h0, 0, 64'h0, 2, 1);
    addVec(6'd58, 64'h44, 64'h0, 5'd3, 0, 64'h0, 1'b0,
           0, 64'h0, 8'h00, 64'h0, 0, 64'h0, 2, 1);
    addVec(6'd33, 64'h3, 64'h0, 5'd3, 0, 64'h0, 1'b0,
           0, 64'h0, 8'h00, 64'h0, 0, 64'h0, 1, 1);
    addVec(6'd34, 64'h7, 64'h0, 5'd31, 3, 64'hAB00_0000_0000_0000, 1'b0,
           4, 64'h0, 8'h80, 64'h0, 1, 64'hAB, 0, 6);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, $sformatf("vec%0d", i), o);
      checkOutput($sformatf("vec%0d", i), vecs[i].e, o);
    end

    // Reset during ISSUE of a load, with ack in the same cycle.
    op_valid  = 1'b1;
    opcode    = 6'd40;
    ea        = 64'h0;
    rd        = 5'd9;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    nextCycle();
    op_valid = 1'b0;
    chk("rstmid req_before", 64'(mem_req), 64'd1);
    rst     = 1'b1;
    mem_ack = 1'b1;
    nextCycle();
    mem_ack = 1'b0;
    chk("rstmid mem_req", 64'(mem_req), 64'd0);
    chk("rstmid wb_en", 64'(wb_en), 64'd0);
    chk("rstmid op_ready_in_rst", 64'(op_ready), 64'd0);
    chk("rstmid errs", 64'({err_misalign, err_illegal, err_timeout}), 64'd0);
    rst = 1'b0;
    nextCycle();
    chk("rstmid op_ready_after", 64'(op_ready), 64'd1);
    chk("rstmid wb_en_after", 64'(wb_en), 64'd0);
    chk("rstmid errs_after", 64'({err_misalign, err_illegal, err_timeout}), 64'd0);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      int b, dl;
      logic [5:0] ops[9];
      ops = '{6'd34, 6'd40, 6'd32, 6'd58, 6'd38, 6'd44, 6'd36, 6'd62, 6'd0};
      s.opcode = ops[$urandom_range(0, 8)];
      if (s.opcode == 6'd0) s.opcode = 6'($urandom);
      s.ea = {$urandom, $urandom};
      b = opBytes(s.opcode);
      if (b > 0 && $urandom_range(0, 3) != 0) s.ea = s.ea & ~(64'(b) - 64'd1);
      s.sd       = {$urandom, $urandom};
      s.rd       = 5'($urandom);
      s.rdata    = {$urandom, $urandom};
      dl         = int'($urandom_range(0, 6));
      s.delay    = (dl == 6) ? -1 : dl;
      s.spurious = 1'($urandom);
      applyStimulus(s, $sformatf("rand%0d", n), o);
      checkOutput($sformatf("rand%0d op%0d ea%0h", n, s.opcode, s.ea), model(s), o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
